intl_core_multi: RTL and testbench
==================================

Name: intl_core_multi

Overview:
- Parametrised successor to the fixed 4-external / 4-H/W interlock core of the MPS PL design.
- Handles N external interlock inputs with per-channel bypass and N H/W fault inputs with per-channel mask, each through a per-channel digital debounce.
- Handles N ADC channels with signed over-threshold checks on both polarities and a persistence filter.
- Latches faults sticky, records the first fault, and runs a trip/clear state machine with an explicit clear acknowledge. Sits between the AXI4-Lite register block and the gate/output logic.

Parameters:
N_EXT, 4, number of external interlock inputs
N_HW, 4, number of H/W fault inputs (OC, POC, OV, OH order)
N_ADC, 2, number of ADC channels checked (ch0 = current, ch1 = voltage)
ADC_W, 32, ADC sample / threshold width, two's complement
DEB_W, 16, debounce counter width
PER_W, 8, persistence counter width
Derived: TOT = N_EXT + N_HW + 2*N_ADC; IDX_W = clog2(TOT), minimum 1.

Ports:
i_clk  in  1  system clock (AXI clock domain)
i_rst  in  1  reset, synchronous, active-low
i_intl_ext  in  N_EXT  external interlock raw, 1 = fault
i_intl_ext_bypass  in  N_EXT  1 = channel ignored for new trips and for clear blocking
i_intl_hw  in  N_HW  H/W fault raw, 1 = fault
i_intl_hw_mask  in  N_HW  1 = channel ignored
i_deb_cnt  in  DEB_W  debounce length in cycles; 0 is treated as 1
i_adc_data  in  N_ADC*ADC_W  signed samples, channel k at [k*ADC_W +: ADC_W]
i_adc_valid  in  N_ADC  per-channel sample strobe
i_thr_p  in  N_ADC*ADC_W  signed positive trip level per channel
i_thr_n  in  N_ADC*ADC_W  signed negative trip level per channel
i_mps_polarity  in  1  0 = unipolar (negative check disabled), 1 = bipolar
i_persist  in  PER_W  consecutive exceeding valid samples needed; 0 is treated as 1
i_intl_clr  in  1  clear request, single-cycle pulse
o_intl_state  out  TOT  latched faults: ext [N_EXT-1:0], then hw, then adc_p[k], then adc_n[k]
o_intl_active  out  TOT  filtered, unlatched fault status, same bit order, before bypass/mask
o_intl_any  out  1  OR of o_intl_state
o_first_idx  out  IDX_W  bit index of the first latched fault
o_first_valid  out  1  o_first_idx is meaningful
o_trip  out  1  one-cycle pulse on ARMED->TRIPPED
o_clr_ack  out  1  one-cycle pulse, clear accepted
o_clr_nack  out  1  one-cycle pulse, clear rejected
o_fsm_state  out  2  0 = ARMED, 1 = TRIPPED, 2 = CLEAR

Behaviour:
- Reset (i_rst = 0 at clock edge): all counters, o_intl_state, o_intl_active, o_first_idx, o_first_valid, o_trip, o_clr_ack and o_clr_nack go to 0; FSM goes to ARMED. This applies equally mid-trip and mid-clear.

Debounce (ext and hw):
- Per-channel counter, saturating at all-ones, increments on each edge where raw = 1 and is zeroed on an edge where raw = 0.
- Filtered bit = 1 from the edge on which the counter reaches D = max(i_deb_cnt, 1). With D = 1, filtered follows raw with 1-cycle latency.
- Deassertion is immediate: filtered = 0 on the first edge where raw = 0.
- A raw glitch shorter than D cycles never asserts filtered.

ADC check (per channel k):
- Acts only on edges where i_adc_valid[k] = 1; counters hold otherwise.
- Exceed_p = data > thr_p, signed compare.
- Exceed_n = i_mps_polarity & (data < thr_n), signed compare. In unipolar mode the n-counter and n-filtered bit are forced to 0.
- Each counter increments on an exceeding valid sample and zeroes on a non-exceeding valid sample. Filtered asserts when the count reaches max(i_persist, 1).

Latching:
- A bit is eligible when its filtered value is 1 and the channel is not bypassed/masked (ADC bits are always eligible).
- Eligible bits OR into o_intl_state on the edge after the filtered bit asserts. Latched bits are sticky; a later bypass does not clear them.

First fault:
- On the edge where o_intl_state goes from 0 to nonzero, o_first_idx = lowest index among the newly set bits and o_first_valid = 1.
- Both hold until the clear is accepted.

FSM:
- ARMED: moves to TRIPPED when o_intl_state becomes nonzero, with o_trip pulsed in that cycle. i_intl_clr is ignored in ARMED; no ack or nack.
- TRIPPED, on i_intl_clr: if any eligible filtered bit is 1, pulse o_clr_nack and stay. Otherwise go to CLEAR.
- A new eligible fault arriving on the same edge as i_intl_clr causes nack; the fault wins.
- CLEAR (one cycle): o_intl_state, o_first_valid and o_first_idx go to 0 and o_clr_ack is pulsed. Next state is ARMED.
- An eligible fault present during CLEAR is latched on the following edge and re-trips from ARMED.

Test Plan:
- Debounce: N_EXT = 4, i_deb_cnt = 5; raw ext2 high for 4 cycles -> no latch. Raw high 5 cycles -> o_intl_state[2] = 1, o_trip pulse, o_first_idx = 2, o_fsm_state = 1.
- Bypass: ext0 bypassed and held high -> o_intl_active[0] = 1, o_intl_state = 0. Then hw1 (bit 5) faults -> latch, o_first_idx = 5. Clear while ext0 still high -> o_clr_ack, state returns to 0.
- ADC: i_persist = 3, thr_p = 1000; valid samples 1001, 1001, 999, 1001, 1001, 1001 -> adc_p0 latches only after the 6th sample.
- Polarity: thr_n = -500, data = -600 with i_persist = 1 -> no fault in unipolar mode; in bipolar mode adc_n0 latches (bit N_EXT+N_HW+N_ADC).
- Clear: hw0 still high when clr is pulsed -> o_clr_nack, state unchanged. Drop hw0, pulse clr -> o_clr_ack, o_intl_any = 0 in the next cycle. Clr on the same edge as a new eligible fault -> nack.
- Reset mid-TRIPPED with a fault latched -> all outputs 0 and ARMED on the next edge.

Source files
------------

// File: rtl/intl_core_multi.sv
// Interlock core: debounced ext/hw inputs, ADC threshold checks,
// sticky fault latch, first-fault capture and trip/clear FSM.
module intl_core_multi #(
  parameter int N_EXT = 4,
  parameter int N_HW  = 4,
  parameter int N_ADC = 2,
  parameter int ADC_W = 32,
  parameter int DEB_W = 16,
  parameter int PER_W = 8,
  localparam int TOT   = N_EXT + N_HW + 2 * N_ADC,
  localparam int IDX_W = (TOT > 1) ? $clog2(TOT) : 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_EXT-1:0]       i_intl_ext,
  input  logic [N_EXT-1:0]       i_intl_ext_bypass,
  input  logic [N_HW-1:0]        i_intl_hw,
  input  logic [N_HW-1:0]        i_intl_hw_mask,
  input  logic [DEB_W-1:0]       i_deb_cnt,
  input  logic [N_ADC*ADC_W-1:0] i_adc_data,
  input  logic [N_ADC-1:0]       i_adc_valid,
  input  logic [N_ADC*ADC_W-1:0] i_thr_p,
  input  logic [N_ADC*ADC_W-1:0] i_thr_n,
  input  logic                   i_mps_polarity,
  input  logic [PER_W-1:0]       i_persist,
  input  logic                   i_intl_clr,
  output logic [TOT-1:0]         o_intl_state,
  output logic [TOT-1:0]         o_intl_active,
  output logic                   o_intl_any,
  output logic [IDX_W-1:0]       o_first_idx,
  output logic                   o_first_valid,
  output logic                   o_trip,
  output logic                   o_clr_ack,
  output logic                   o_clr_nack,
  output logic [1:0]             o_fsm_state
);

  localparam int NDIG = N_EXT + N_HW;

  localparam logic [1:0] ARMED   = 2'd0;
  localparam logic [1:0] TRIPPED = 2'd1;
  localparam logic [1:0] CLEAR   = 2'd2;

  logic [DEB_W-1:0] deb_lim;
  logic [PER_W-1:0] per_lim;
  logic [NDIG-1:0]  dig_raw;
  logic [NDIG-1:0]  dig_act;
  logic [N_ADC-1:0] adc_p;
  logic [N_ADC-1:0] adc_n;
  logic [TOT-1:0]   ign;
  logic [TOT-1:0]   elig;
  logic [IDX_W-1:0] low;
  logic [1:0]       fsm;

  assign deb_lim = (i_deb_cnt == '0) ? DEB_W'(1) : i_deb_cnt;
  assign per_lim = (i_persist == '0) ? PER_W'(1) : i_persist;
  assign dig_raw = {i_intl_hw, i_intl_ext};

  for (genvar i = 0; i < NDIG; i++) begin : g_deb
    logic [DEB_W-1:0] cnt;
    // Count consecutive high raw cycles, drop to zero on any low
    always_ff @(posedge i_clk) begin
      if (!i_rst || !dig_raw[i]) cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;
    end
    assign dig_act[i] = (cnt >= deb_lim);
  end

  for (genvar k = 0; k < N_ADC; k++) begin : g_adc
    logic signed [ADC_W-1:0] d;
    logic signed [ADC_W-1:0] tp;
    logic signed [ADC_W-1:0] tn;
    logic [PER_W-1:0] cp;
    logic [PER_W-1:0] cn;
    logic ex_p;
    logic ex_n;
    assign d    = i_adc_data[k*ADC_W +: ADC_W];
    assign tp   = i_thr_p[k*ADC_W +: ADC_W];
    assign tn   = i_thr_n[k*ADC_W +: ADC_W];
    assign ex_p = (d > tp);
    assign ex_n = i_mps_polarity & (d < tn);
    // Positive persistence: run length of exceeding valid samples
    always_ff @(posedge i_clk) begin
      if (!i_rst) cp <= '0;
      else if (i_adc_valid[k]) begin
        if (!ex_p) cp <= '0;
        else if (cp != '1) cp <= cp + 1'b1;
      end
    end
    // Negative persistence, held at zero in unipolar mode
    always_ff @(posedge i_clk) begin
      if (!i_rst || !i_mps_polarity) cn <= '0;
      else if (i_adc_valid[k]) begin
        if (!ex_n) cn <= '0;
        else if (cn != '1) cn <= cn + 1'b1;
      end
    end
    assign adc_p[k] = (cp >= per_lim);
    assign adc_n[k] = i_mps_polarity & (cn >= per_lim);
  end

  assign o_intl_active = {adc_n, adc_p, dig_act};
  assign ign  = {{(2*N_ADC){1'b0}}, i_intl_hw_mask, i_intl_ext_bypass};
  assign elig = o_intl_active & ~ign;
  assign o_intl_any  = |o_intl_state;
  assign o_fsm_state = fsm;

  // Lowest set index among eligible bits
  always_comb begin
    low = '0;
    for (int i = TOT - 1; i >= 0; i--)
      if (elig[i]) low = IDX_W'(i);
  end

  // Sticky latch, first-fault capture and trip/clear sequencing
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_intl_state  <= '0;
      o_first_idx   <= '0;
      o_first_valid <= 1'b0;
      o_trip        <= 1'b0;
      o_clr_ack     <= 1'b0;
      o_clr_nack    <= 1'b0;
      fsm           <= ARMED;
    end else begin
      o_trip     <= 1'b0;
      o_clr_ack  <= 1'b0;
      o_clr_nack <= 1'b0;
      if (fsm == TRIPPED && i_intl_clr && elig == '0) begin
        o_intl_state  <= '0;
        o_first_idx   <= '0;
        o_first_valid <= 1'b0;
        o_clr_ack     <= 1'b1;
        fsm           <= CLEAR;
      end else begin
        o_intl_state <= o_intl_state | elig;
        if (o_intl_state == '0 && elig != '0) begin
          o_first_idx   <= low;
          o_first_valid <= 1'b1;
        end
        unique case (fsm)
          ARMED: begin
            if ((o_intl_state | elig) != '0) begin
              fsm    <= TRIPPED;
              o_trip <= 1'b1;
            end
          end
          TRIPPED: begin
            if (i_intl_clr) o_clr_nack <= 1'b1;
          end
          CLEAR:   fsm <= ARMED;
          default: fsm <= ARMED;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_intl_core_multi.sv
// Bench for intl_core_multi: directed plan scenarios plus random
// stimulus, every cycle compared against a run-length reference model.
module tb_intl_core_multi;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  ext, byp, hw, msk;
  logic [15:0] deb;
  logic [63:0] adc, thp, thn;
  logic [1:0]  avld;
  logic        pol;
  logic [7:0]  per;
  logic        clr;
  logic [11:0] st, act;
  logic        any;
  logic [3:0]  fidx;
  logic        fv, trip, ack, nack;
  logic [1:0]  fsm;

  always #5 clk = ~clk;

  intl_core_multi dut (
    .i_clk(clk), .i_rst(rst),
    .i_intl_ext(ext), .i_intl_ext_bypass(byp),
    .i_intl_hw(hw), .i_intl_hw_mask(msk),
    .i_deb_cnt(deb), .i_adc_data(adc), .i_adc_valid(avld),
    .i_thr_p(thp), .i_thr_n(thn), .i_mps_polarity(pol),
    .i_persist(per), .i_intl_clr(clr),
    .o_intl_state(st), .o_intl_active(act), .o_intl_any(any),
    .o_first_idx(fidx), .o_first_valid(fv), .o_trip(trip),
    .o_clr_ack(ack), .o_clr_nack(nack), .o_fsm_state(fsm)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: run lengths of raw-high cycles / exceeding samples
  int run_d [8];
  int run_p [2];
  int run_n [2];
  logic [11:0] m_st;
  int m_first, m_fsm;
  bit m_fv, m_trip, m_ack, m_nack;

  function automatic logic [11:0] m_active();
    logic [11:0] a;
    int d, p;
    d = (deb == 0) ? 1 : int'(deb);
    p = (per == 0) ? 1 : int'(per);
    a = '0;
    for (int i = 0; i < 8; i++) a[i] = (run_d[i] >= d);
    for (int k = 0; k < 2; k++) begin
      a[8+k]  = (run_p[k] >= p);
      a[10+k] = pol && (run_n[k] >= p);
    end
    return a;
  endfunction

  task automatic model_edge();
    logic [11:0] e;
    logic [7:0]  raw;
    int v, tp, tn;
    if (!rst) begin
      foreach (run_d[i]) run_d[i] = 0;
      foreach (run_p[k]) begin run_p[k] = 0; run_n[k] = 0; end
      m_st = '0; m_first = 0; m_fsm = 0;
      m_fv = 0; m_trip = 0; m_ack = 0; m_nack = 0;
      return;
    end
    e = m_active() & ~{4'b0, msk, byp};
    m_trip = 0; m_ack = 0; m_nack = 0;
    if (m_fsm == 1 && clr && e == 0) begin
      m_st = '0; m_fv = 0; m_first = 0; m_ack = 1; m_fsm = 2;
    end else begin
      if (m_st == 0 && e != 0) begin
        m_fv = 1;
        for (int i = 0; i < 12; i++)
          if (e[i]) begin m_first = i; break; end
      end
      m_st = m_st | e;
      if (m_fsm == 0) begin
        if (m_st != 0) begin m_fsm = 1; m_trip = 1; end
      end else if (m_fsm == 1) begin
        if (clr) m_nack = 1;
      end else begin
        m_fsm = 0;
      end
    end
    raw = {hw, ext};
    for (int i = 0; i < 8; i++) run_d[i] = raw[i] ? run_d[i] + 1 : 0;
    for (int k = 0; k < 2; k++) begin
      v  = int'(signed'(adc[k*32 +: 32]));
      tp = int'(signed'(thp[k*32 +: 32]));
      tn = int'(signed'(thn[k*32 +: 32]));
      if (avld[k]) run_p[k] = (v > tp) ? run_p[k] + 1 : 0;
      if (!pol) run_n[k] = 0;
      else if (avld[k]) run_n[k] = (v < tn) ? run_n[k] + 1 : 0;
    end
  endtask

  task automatic cyc();
    model_edge();
    @(posedge clk);
    #1;
    check("state", 64'(st), 64'(m_st));
    check("active", 64'(act), 64'(m_active()));
    check("any", 64'(any), 64'(m_st != 0));
    check("first_idx", 64'(fidx), 64'(m_first));
    check("first_valid", 64'(fv), 64'(m_fv));
    check("trip", 64'(trip), 64'(m_trip));
    check("ack", 64'(ack), 64'(m_ack));
    check("nack", 64'(nack), 64'(m_nack));
    check("fsm", 64'(fsm), 64'(m_fsm));
  endtask

  task automatic cycn(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic recover();
    ext = '0; hw = '0; adc = '0; avld = 2'b11;
    cyc();
    avld = '0;
    cycn(2);
    clr = 1'b1; cyc(); clr = 1'b0;
    cycn(2);
    check("recover_fsm", 64'(fsm), 64'd0);
  endtask

  task automatic set_adc0(int v);
    adc[31:0] = 32'(v);
  endtask

  initial begin
    int sv [6];
    rst = 1'b0; ext = '0; byp = '0; hw = '0; msk = '0;
    deb = 16'd1; per = 8'd1; pol = 1'b0; clr = 1'b0;
    adc = '0; avld = '0;
    thp = {32'sd200, 32'sd1000};
    thn = {-32'sd200, -32'sd500};
    cycn(2);
    check("rst_state", 64'(st), 64'd0);
    check("rst_fsm", 64'(fsm), 64'd0);
    rst = 1'b1;
    cyc();

    // debounce: 4-cycle glitch ignored, 5 cycles latch bit 2
    deb = 16'd5;
    ext = 4'b0100; cycn(4);
    ext = 4'b0000; cycn(3);
    check("glitch_state", 64'(st), 64'd0);
    ext = 4'b0100; cycn(5);
    ext = 4'b0000; cyc();
    check("deb_state", 64'(st), 64'h004);
    check("deb_trip", 64'(trip), 64'd1);
    check("deb_first", 64'(fidx), 64'd2);
    check("deb_fsm", 64'(fsm), 64'd1);
    recover();

    // bypass: ext0 active but ignored, hw1 latches bit 5
    deb = 16'd1;
    byp = 4'b0001; ext = 4'b0001; cycn(3);
    check("byp_active0", 64'(act[0]), 64'd1);
    check("byp_state", 64'(st), 64'd0);
    hw = 4'b0010; cycn(2);
    check("byp_first", 64'(fidx), 64'd5);
    check("byp_latch", 64'(st), 64'h020);
    hw = 4'b0000; cycn(2);
    clr = 1'b1; cyc(); clr = 1'b0;
    check("byp_ack", 64'(ack), 64'd1);
    check("byp_cleared", 64'(st), 64'd0);
    cycn(2);
    ext = 4'b0000; cyc();
    byp = 4'b0000; cyc();

    // ADC persistence 3 on channel 0
    per = 8'd3;
    sv = '{1001, 1001, 999, 1001, 1001, 1001};
    for (int i = 0; i < 6; i++) begin
      set_adc0(sv[i]); avld = 2'b01; cyc();
      if (i == 4) check("adc_early", 64'(st), 64'd0);
    end
    avld = '0; cyc();
    check("adc_latch", 64'(st), 64'h100);
    recover();

    // polarity: negative check only in bipolar mode
    per = 8'd1;
    set_adc0(-600); avld = 2'b01; cyc();
    avld = '0; cycn(2);
    check("unipolar", 64'(st), 64'd0);
    pol = 1'b1;
    avld = 2'b01; cyc();
    avld = '0; cyc();
    check("bipolar", 64'(st), 64'h400);
    recover();
    pol = 1'b0;

    // clear with fault present, then clean clear, then clr racing a new fault
    hw = 4'b0001; cycn(2);
    clr = 1'b1; cyc(); clr = 1'b0;
    check("clr_nack", 64'(nack), 64'd1);
    check("clr_stay", 64'(fsm), 64'd1);
    hw = 4'b0000; cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    check("clr_ack", 64'(ack), 64'd1);
    check("clr_any", 64'(any), 64'd0);
    cycn(2);
    hw = 4'b0001; cycn(2);
    hw = 4'b0000; cyc();
    ext = 4'b1000; cyc();
    clr = 1'b1; cyc(); clr = 1'b0;
    check("race_nack", 64'(nack), 64'd1);
    check("race_state", 64'(st), 64'h018);
    recover();

    // reset while tripped
    hw = 4'b0001; cycn(2);
    check("pre_rst_fsm", 64'(fsm), 64'd1);
    rst = 1'b0; cyc();
    check("mid_rst_state", 64'(st), 64'd0);
    check("mid_rst_fsm", 64'(fsm), 64'd0);
    check("mid_rst_fv", 64'(fv), 64'd0);
    rst = 1'b1; hw = 4'b0000; cyc();

    // random stimulus against the model
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) ext = 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 5) == 0) hw  = 4'($urandom & $urandom & $urandom);
      if ($urandom_range(0, 30) == 0) byp = 4'($urandom);
      if ($urandom_range(0, 30) == 0) msk = 4'($urandom);
      if ($urandom_range(0, 40) == 0) deb = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 40) == 0) per = 8'($urandom_range(0, 3));
      if ($urandom_range(0, 50) == 0) pol = 1'($urandom);
      for (int k = 0; k < 2; k++)
        adc[k*32 +: 32] = 32'(int'($urandom_range(0, 3000)) - 1500);
      avld = 2'($urandom);
      clr  = ($urandom_range(0, 7) == 0);
      rst  = ($urandom_range(0, 99) != 0);
      cyc();
    end
    rst = 1'b1; clr = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
